// File: rtl/saturn_rstk_pkg.sv
// Saturn return-stack package: RTN-family kind codes, return FSM state encoding,
// stack geometry and the return-condition helper shared by the return unit.
// Optional debug/trace build: define SATURN_RSTK_DBG_EN.
package saturn_rstk_pkg;

    localparam int RSTK_DEPTH  = 8;
    localparam int RSTK_PTR_W  = 3;
    localparam int RSTK_ADDR_W = 20;

    localparam logic [2:0] RTN_RTN    = 3'd0;
    localparam logic [2:0] RTN_RTNSXM = 3'd1;
    localparam logic [2:0] RTN_RTNSC  = 3'd2;
    localparam logic [2:0] RTN_RTNCC  = 3'd3;
    localparam logic [2:0] RTN_RTNC   = 3'd4;
    localparam logic [2:0] RTN_RTNNC  = 3'd5;
    localparam logic [2:0] RTN_RTI    = 3'd6;
    localparam logic [2:0] RTN_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_LOAD = 2'd2
    } rstk_state_t;

    // Conditional returns test the carry flag; the reserved code never returns.
    function automatic logic rtn_taken(input logic [2:0] kind, input logic carry);
        case (kind)
            RTN_RTNC:  return carry;
            RTN_RTNNC: return !carry;
            RTN_RSVD:  return 1'b0;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/saturn_rstk_lifo.sv
// Saturn return stack storage: circular entry array with a top pointer and a
// saturating depth counter. Push at full overwrites the oldest entry; pop of an
// empty stack reads zero; push+pop together replaces the top in place.
// Debug read port is live only when SATURN_RSTK_DBG_EN is defined.
module saturn_rstk_lifo
    import saturn_rstk_pkg::*;
#(
    parameter int DEPTH  = RSTK_DEPTH,
    parameter int PTR_W  = RSTK_PTR_W,
    parameter int ADDR_W = RSTK_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_val,
    input  logic              pop,
    output logic [ADDR_W-1:0] top_val,
    input  logic [PTR_W-1:0]  dbg_ptr,
    output logic [ADDR_W-1:0] dbg_val,
    output logic [PTR_W:0]    dbg_depth
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W:0]    depth;

    // An empty stack always reads as zero, even if a replace left data under the pointer.
    assign top_val = (depth == '0) ? '0 : entries[ptr];

    // Stack update: replace, push, or pop; entries are cleared by reset rather than a sweep.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            ptr   <= PTR_W'(DEPTH - 1);
            depth <= '0;
        end else if (push && pop) begin
            entries[ptr] <= push_val;
        end else if (push) begin
            entries[ptr + PTR_W'(1)] <= push_val;
            ptr <= ptr + PTR_W'(1);
            if (depth != FULL) begin
                depth <= depth + (PTR_W + 1)'(1);
            end
        end else if (pop) begin
            entries[ptr] <= '0;
            ptr <= ptr - PTR_W'(1);
            if (depth != '0) begin
                depth <= depth - (PTR_W + 1)'(1);
            end
        end
    end

`ifdef SATURN_RSTK_DBG_EN
    assign dbg_val   = entries[dbg_ptr];
    assign dbg_depth = depth;
`else
    logic unused_dbg_ptr;
    assign unused_dbg_ptr = ^dbg_ptr;
    assign dbg_val   = '0;
    assign dbg_depth = '0;
`endif

endmodule

// File: rtl/saturn_rstk_return_unit.sv
// Saturn return unit: owns the return stack, runs the RTN-family return sequence
// (latch kind, evaluate condition and pop, load PC) on the phase ring, and serves
// C=RSTK pops and RSTK pushes. All strobes are registered and last one clock.
// Define SATURN_RSTK_DBG_EN for the debug read port and a push/pop/FSM trace.
module saturn_rstk_return_unit
    import saturn_rstk_pkg::*;
#(
    parameter int DEPTH  = RSTK_DEPTH,
    parameter int PTR_W  = RSTK_PTR_W,
    parameter int ADDR_W = RSTK_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clk_en,
    input  logic [3:0]        i_phases,
    input  logic [1:0]        i_phase,
    input  logic [31:0]       i_cycle_ctr,
    input  logic              i_bus_busy,
    input  logic              i_rtn_instr,
    input  logic [2:0]        i_rtn_kind,
    input  logic              i_carry,
    input  logic              i_push_req,
    input  logic [ADDR_W-1:0] i_push_val,
    input  logic              i_pop_req,
    output logic [ADDR_W-1:0] o_pop_val,
    output logic              o_pop_valid,
    output logic [ADDR_W-1:0] o_new_pc,
    output logic              o_reload_pc,
    output logic              o_pc_load,
    output logic              o_set_carry,
    output logic              o_clr_carry,
    output logic              o_set_xm,
    output logic              o_rti,
    input  logic [PTR_W-1:0]  i_dbg_rstk_ptr,
    output logic [ADDR_W-1:0] o_dbg_rstk_val,
    output logic [PTR_W:0]    o_dbg_depth
);

    rstk_state_t       state_q;
    rstk_state_t       state_d;
    logic [2:0]        kind_q;
    logic              en;
    logic              latch_kind;
    logic              fsm_pop;
    logic              load_fire;
    logic              user_push;
    logic              user_pop;
    logic [ADDR_W-1:0] top_val;

    // Only phases 0 and 3 sequence this unit.
    logic unused_phase_bits;
    assign unused_phase_bits = ^i_phases[2:1];

    assign en        = i_clk_en && !i_bus_busy;
    assign user_push = en && i_phases[3] && i_push_req;
    assign user_pop  = en && i_phases[3] && i_pop_req;

    saturn_rstk_lifo #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .ADDR_W (ADDR_W)
    ) u_lifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push      (user_push),
        .push_val  (i_push_val),
        .pop       (user_pop || fsm_pop),
        .top_val   (top_val),
        .dbg_ptr   (i_dbg_rstk_ptr),
        .dbg_val   (o_dbg_rstk_val),
        .dbg_depth (o_dbg_depth)
    );

    // Return FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Return FSM next state: latch, evaluate, then load on the following phase 3.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (en && i_phases[3] && i_rtn_instr) state_d = S_EVAL;
            S_EVAL: if (en && i_phases[0]) state_d = rtn_taken(kind_q, i_carry) ? S_LOAD : S_IDLE;
            S_LOAD: if (en && i_phases[3]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Return FSM actions decoded from the current state.
    always_comb begin
        latch_kind = 1'b0;
        fsm_pop    = 1'b0;
        load_fire  = 1'b0;
        case (state_q)
            S_IDLE: latch_kind = en && i_phases[3] && i_rtn_instr;
            S_EVAL: fsm_pop    = en && i_phases[0] && rtn_taken(kind_q, i_carry);
            S_LOAD: load_fire  = en && i_phases[3];
            default: ;
        endcase
    end

    // Hold the return kind from latch until the PC load strobes are issued.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            kind_q <= RTN_RTN;
        end else if (latch_kind) begin
            kind_q <= i_rtn_kind;
        end
    end

    // Registered outputs; strobes clear every clock so they last exactly one cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pop_val   <= '0;
            o_pop_valid <= 1'b0;
            o_new_pc    <= '0;
            o_reload_pc <= 1'b0;
            o_pc_load   <= 1'b0;
            o_set_carry <= 1'b0;
            o_clr_carry <= 1'b0;
            o_set_xm    <= 1'b0;
            o_rti       <= 1'b0;
        end else begin
            o_pop_valid <= 1'b0;
            o_pc_load   <= 1'b0;
            o_set_carry <= 1'b0;
            o_clr_carry <= 1'b0;
            o_set_xm    <= 1'b0;
            o_rti       <= 1'b0;
            if (user_pop) begin
                o_pop_val   <= top_val;
                o_pop_valid <= 1'b1;
            end
            if (fsm_pop) begin
                o_new_pc    <= top_val;
                o_reload_pc <= 1'b1;
            end
            if (load_fire) begin
                o_pc_load   <= 1'b1;
                o_reload_pc <= 1'b0;
                o_set_carry <= (kind_q == RTN_RTNSC);
                o_clr_carry <= (kind_q == RTN_RTNCC);
                o_set_xm    <= (kind_q == RTN_RTNSXM);
                o_rti       <= (kind_q == RTN_RTI);
            end
        end
    end

`ifdef SATURN_RSTK_DBG_EN
    // Simulation trace of stack traffic and FSM transitions.
    always @(posedge i_clk) begin
        if (!i_reset) begin
            if (user_push)
                $display("[RSTK] push %05h phase %0d cycle %0d", i_push_val, i_phase, i_cycle_ctr);
            if (user_pop || fsm_pop)
                $display("[RSTK] pop %05h phase %0d cycle %0d", top_val, i_phase, i_cycle_ctr);
            if (state_d != state_q)
                $display("[RSTK] fsm %s -> %s phase %0d cycle %0d", state_q.name(), state_d.name(), i_phase, i_cycle_ctr);
        end
    end
`else
    logic unused_trace;
    assign unused_trace = ^{i_phase, i_cycle_ctr};
`endif

endmodule

// File: tb/tb_saturn_rstk_return_unit.sv
// Self-checking bench for saturn_rstk_return_unit: directed return-stack scenarios
// followed by randomized traffic, all compared against a queue-based reference model.
// Debug outputs are expected tied to zero unless SATURN_RSTK_DBG_EN is defined.
module tb_saturn_rstk_return_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [3:0]  phases;
    logic [1:0]  phase;
    logic [31:0] cycle_ctr;
    logic        bus_busy;
    logic        rtn_instr;
    logic [2:0]  rtn_kind;
    logic        carry;
    logic        push_req;
    logic [19:0] push_val;
    logic        pop_req;
    logic [19:0] pop_val;
    logic        pop_valid;
    logic [19:0] new_pc;
    logic        reload_pc;
    logic        pc_load;
    logic        set_carry;
    logic        clr_carry;
    logic        set_xm;
    logic        rti;
    logic [2:0]  dbg_ptr;
    logic [19:0] dbg_val;
    logic [3:0]  dbg_depth;

    int checks = 0;
    int errors = 0;
    int pidx = 0;
    int load_cnt = 0;
    bit reload_seen = 0;
    bit last_sc = 0;

    // Reference model: stack as a queue (newest at the back), return progress as a mode.
    logic [19:0] stk[$];
    int          m_mode;
    logic [2:0]  m_kind;
    logic [19:0] m_pop_val, m_new_pc;
    bit          m_pop_valid, m_reload, m_pc_load, m_sc, m_cc, m_xm, m_rti;

    saturn_rstk_return_unit dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_clk_en       (clk_en),
        .i_phases       (phases),
        .i_phase        (phase),
        .i_cycle_ctr    (cycle_ctr),
        .i_bus_busy     (bus_busy),
        .i_rtn_instr    (rtn_instr),
        .i_rtn_kind     (rtn_kind),
        .i_carry        (carry),
        .i_push_req     (push_req),
        .i_push_val     (push_val),
        .i_pop_req      (pop_req),
        .o_pop_val      (pop_val),
        .o_pop_valid    (pop_valid),
        .o_new_pc       (new_pc),
        .o_reload_pc    (reload_pc),
        .o_pc_load      (pc_load),
        .o_set_carry    (set_carry),
        .o_clr_carry    (clr_carry),
        .o_set_xm       (set_xm),
        .o_rti          (rti),
        .i_dbg_rstk_ptr (dbg_ptr),
        .o_dbg_rstk_val (dbg_val),
        .o_dbg_depth    (dbg_depth)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_ctr <= cycle_ctr + 32'd1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic bit modelTaken(input logic [2:0] k, input bit c);
        if (k == 3'd4) return c;
        if (k == 3'd5) return !c;
        return (k != 3'd7);
    endfunction

    task automatic modelReset();
        stk.delete();
        m_mode = 0;
        m_kind = 3'd0;
        m_pop_val = '0;
        m_new_pc = '0;
        {m_pop_valid, m_reload, m_pc_load, m_sc, m_cc, m_xm, m_rti} = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit do_push, do_upop, do_fpop, do_load;
        logic [19:0] top;
        {m_pop_valid, m_pc_load, m_sc, m_cc, m_xm, m_rti} = '0;
        if (clk_en && !bus_busy) begin
            do_push = phases[3] && push_req;
            do_upop = phases[3] && pop_req;
            do_fpop = 0;
            do_load = 0;
            if (m_mode == 0) begin
                if (phases[3] && rtn_instr) begin m_kind = rtn_kind; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (phases[0]) begin
                    if (modelTaken(m_kind, carry)) begin do_fpop = 1; m_mode = 2; end
                    else m_mode = 0;
                end
            end else begin
                if (phases[3]) begin do_load = 1; m_mode = 0; end
            end
            top = (stk.size() == 0) ? 20'h0 : stk[$];
            if (do_upop || do_fpop) begin
                if (do_push) begin
                    if (stk.size() != 0) stk[stk.size() - 1] = push_val;
                end else if (stk.size() != 0) begin
                    void'(stk.pop_back());
                end
            end else if (do_push) begin
                stk.push_back(push_val);
                if (stk.size() > 8) void'(stk.pop_front());
            end
            if (do_upop) begin m_pop_val = top; m_pop_valid = 1; end
            if (do_fpop) begin m_new_pc = top; m_reload = 1; end
            if (do_load) begin
                m_pc_load = 1;
                m_reload = 0;
                m_sc  = (m_kind == 3'd2);
                m_cc  = (m_kind == 3'd3);
                m_xm  = (m_kind == 3'd1);
                m_rti = (m_kind == 3'd6);
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("pop_val", pop_val, m_pop_val);
        checkOutput("pop_valid", pop_valid, m_pop_valid);
        checkOutput("new_pc", new_pc, m_new_pc);
        checkOutput("reload_pc", reload_pc, m_reload);
        checkOutput("pc_load", pc_load, m_pc_load);
        checkOutput("set_carry", set_carry, m_sc);
        checkOutput("clr_carry", clr_carry, m_cc);
        checkOutput("set_xm", set_xm, m_xm);
        checkOutput("rti", rti, m_rti);
`ifdef SATURN_RSTK_DBG_EN
        checkOutput("dbg_depth", dbg_depth, stk.size());
`else
        checkOutput("dbg_depth", dbg_depth, 0);
        checkOutput("dbg_val", dbg_val, 0);
`endif
        if (pc_load) begin load_cnt++; last_sc = set_carry; end
        if (reload_pc) reload_seen = 1;
    endtask

    // Drive one clock of inputs, step the model, then compare after the edge.
    task automatic applyStimulus(input bit rtn, input logic [2:0] kind, input bit c, input bit push,
                                 input logic [19:0] pv, input bit upop, input bit busy, input bit cen);
        rtn_instr = rtn;
        rtn_kind  = kind;
        carry     = c;
        push_req  = push;
        push_val  = pv;
        pop_req   = upop;
        bus_busy  = busy;
        clk_en    = cen;
        phases    = 4'b0001 << pidx;
        phase     = 2'(pidx);
        dbg_ptr   = 3'($urandom_range(0, 7));
        modelStep();
        @(posedge clk);
        #1;
        if (cen && !busy) pidx = (pidx + 1) % 4;
        compareAll();
    endtask

    task automatic idle(input bit c);
        applyStimulus(0, 3'd0, c, 0, 20'h0, 0, 0, 1);
    endtask

    task automatic runTo3();
        while (pidx != 3) idle(0);
    endtask

    task automatic pushVal(input logic [19:0] v);
        runTo3();
        applyStimulus(0, 3'd0, 0, 1, v, 0, 0, 1);
    endtask

    task automatic userPop();
        runTo3();
        applyStimulus(0, 3'd0, 0, 0, 20'h0, 1, 0, 1);
    endtask

    task automatic doReturn(input logic [2:0] kind, input bit c);
        runTo3();
        applyStimulus(1, kind, c, 0, 20'h0, 0, 0, 1);
        repeat (5) idle(c);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        #1;
        modelReset();
        pidx = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int base;
        {clk_en, bus_busy, rtn_instr, carry, push_req, pop_req} = '0;
        rtn_kind = 3'd0; push_val = '0; phases = 4'b0001; phase = 2'd0; dbg_ptr = 3'd0;
        cycle_ctr = 32'd0;
        applyReset();
        checkOutput("reset_new_pc", new_pc, 0);
        checkOutput("reset_reload", reload_pc, 0);
        checkOutput("reset_pc_load", pc_load, 0);
        checkOutput("reset_pop_valid", pop_valid, 0);

        // RTN on an empty stack.
        doReturn(3'd0, 0);
        checkOutput("empty_rtn_pc", new_pc, 20'h00000);
        checkOutput("empty_rtn_loads", load_cnt, 1);
        userPop();
        idle(0);
        checkOutput("empty_still_zero", pop_val, 20'h00000);

        // Two pushes, RTN returns the newest, C=RSTK the older, then empty.
        pushVal(20'h12345);
        pushVal(20'h6789A);
        doReturn(3'd0, 0);
        checkOutput("rtn_6789a", new_pc, 20'h6789A);
        userPop();
        checkOutput("crstk_12345", pop_val, 20'h12345);
        checkOutput("crstk_valid", pop_valid, 1);
        userPop();
        checkOutput("crstk_empty", pop_val, 20'h00000);

        // Nine pushes overwrite the oldest entry.
        for (int i = 1; i <= 9; i++) pushVal(20'(i));
        for (int i = 9; i >= 1; i--) begin
            userPop();
            checkOutput("overflow_pop", pop_val, (i >= 2) ? 32'(i) : 32'h0);
        end

        // Conditional returns on carry, and RTNSC strobe alignment.
        pushVal(20'h11111);
        reload_seen = 0;
        base = load_cnt;
        doReturn(3'd4, 0);
        checkOutput("rtnc_c0_no_reload", reload_seen, 0);
        checkOutput("rtnc_c0_no_load", load_cnt, base);
        doReturn(3'd4, 1);
        checkOutput("rtnc_c1_pc", new_pc, 20'h11111);
        checkOutput("rtnc_c1_load", load_cnt, base + 1);
        pushVal(20'h22222);
        last_sc = 0;
        doReturn(3'd2, 0);
        checkOutput("rtnsc_set_carry", last_sc, 1);
        checkOutput("rtnsc_pc", new_pc, 20'h22222);

        // Push and C=RSTK in one cycle replace the top.
        pushVal(20'h55555);
        pushVal(20'hAAAAA);
        runTo3();
        applyStimulus(0, 3'd0, 0, 1, 20'hBBBBB, 1, 0, 1);
        checkOutput("replace_pop_old_top", pop_val, 20'hAAAAA);
        userPop();
        checkOutput("replace_new_top", pop_val, 20'hBBBBB);
        userPop();
        checkOutput("replace_depth2", pop_val, 20'h55555);
        userPop();
        checkOutput("replace_then_empty", pop_val, 20'h00000);

        // Async reset while the return waits to load.
        pushVal(20'h77777);
        runTo3();
        applyStimulus(1, 3'd0, 0, 0, 20'h0, 0, 0, 1);
        idle(0);
        checkOutput("pre_reset_reload", reload_pc, 1);
        base = load_cnt;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_reload", reload_pc, 0);
        checkOutput("async_reset_new_pc", new_pc, 0);
        modelReset();
        pidx = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) idle(0);
        checkOutput("no_load_after_reset", load_cnt, base);
        userPop();
        checkOutput("reset_emptied_stack", pop_val, 20'h00000);

        // Bus busy across phase 3 delays the latch.
        pushVal(20'h33333);
        runTo3();
        repeat (3) applyStimulus(1, 3'd0, 0, 0, 20'h0, 0, 1, 1);
        checkOutput("busy_no_reload", reload_pc, 0);
        applyStimulus(1, 3'd0, 0, 0, 20'h0, 0, 0, 1);
        idle(0);
        checkOutput("busy_release_reload", reload_pc, 1);
        checkOutput("busy_release_pc", new_pc, 20'h33333);
        repeat (4) idle(0);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0), 20'($urandom), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
